i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target.sv | 245 ++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
`timescale 1ns/1ps
// I2C target: 7-bit address, 2-byte write word to rx_data, 2-byte read word from tx_data.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter on SCL and SDA.
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h4C,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] tx_data,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   w_scl_s, w_sda_s;
  logic                   r_scl_d, r_sda_d;
  logic                   w_scl_rise, w_scl_fall, w_start, w_stop;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic       w_scl_raw, w_sda_raw;
  logic [1:0] r_scl_hist, r_sda_hist;
  logic       r_scl_flt, r_sda_flt;

  assign w_scl_raw = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_raw = r_sda_sync[SYNC_STAGES-1];

  // Registered 2-of-3 vote: a single-clk pulse never wins, a real edge costs 2 clk.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_scl_hist <= '1;
      r_sda_hist <= '1;
      r_scl_flt  <= 1'b1;
      r_sda_flt  <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[0], w_scl_raw};
      r_sda_hist <= {r_sda_hist[0], w_sda_raw};
      r_scl_flt  <= (w_scl_raw & r_scl_hist[0]) | (w_scl_raw & r_scl_hist[1]) |
                    (r_scl_hist[0] & r_scl_hist[1]);
      r_sda_flt  <= (w_sda_raw & r_sda_hist[0]) | (w_sda_raw & r_sda_hist[1]) |
                    (r_sda_hist[0] & r_sda_hist[1]);
    end

  assign w_scl_s = r_scl_flt;
  assign w_sda_s = r_sda_flt;
`else
  assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s = r_sda_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl_s;
      r_sda_d <= w_sda_s;
    end

  assign w_scl_rise = w_scl_s & ~r_scl_d;
  assign w_scl_fall = ~w_scl_s & r_scl_d;
  assign w_start    = w_scl_s & r_scl_d & r_sda_d & ~w_sda_s;
  assign w_stop     = w_scl_s & r_scl_d & ~r_sda_d & w_sda_s;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic [1:0]  r_byte_cnt, w_byte_cnt_nxt;
  logic [7:0]  r_wr_hi, w_wr_hi_nxt;
  logic [15:0] r_tx_word, w_tx_word_nxt;
  logic        r_ack, w_ack_nxt;
  logic        r_sda_oe, w_sda_oe_nxt;
  logic        r_busy, w_busy_nxt;
  logic [15:0] r_rx_data, w_rx_data_nxt;
  logic        r_rx_valid, w_rx_valid_nxt;
  logic [7:0]  w_rd_byte;

  // rx_valid is a single-clk strobe with no back-pressure: the consumer must take
  // rx_data in the cycle rx_valid is high; rx_data then holds until the next word.
  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_byte_cnt_nxt = r_byte_cnt;
    w_wr_hi_nxt    = r_wr_hi;
    w_tx_word_nxt  = r_tx_word;
    w_ack_nxt      = r_ack;
    w_sda_oe_nxt   = r_sda_oe;
    w_busy_nxt     = r_busy;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_rd_byte      = (r_byte_cnt == 2'd0) ? r_tx_word[7:0] : 8'hFF;

    if (w_stop) begin
      w_state_nxt  = IDLE;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_start) begin
      w_state_nxt   = ADDR;
      w_bit_cnt_nxt = 4'd0;
      w_sda_oe_nxt  = 1'b0;
    end else begin
      case (r_state)
        ADDR: begin
          if (w_scl_rise && r_bit_cnt != 4'd8) begin
            w_shift_nxt   = {r_shift[6:0], w_sda_s};
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
            if (r_shift[7:1] == TARGET_ADDR) begin
              w_state_nxt   = ADDR_ACK;
              w_sda_oe_nxt  = 1'b1;
              w_busy_nxt    = 1'b1;
              w_tx_word_nxt = tx_data;
            end else begin
              w_state_nxt = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (w_scl_fall) begin
            w_bit_cnt_nxt  = 4'd0;
            w_byte_cnt_nxt = 2'd0;
            if (r_shift[0]) begin
              w_state_nxt  = RD_BYTE;
              w_sda_oe_nxt = ~r_tx_word[15];
              w_shift_nxt  = {r_tx_word[14:8], 1'b0};
            end else begin
              w_state_nxt  = WR_BYTE;
              w_sda_oe_nxt = 1'b0;
            end
          end
        end
        WR_BYTE: begin
          if (w_scl_rise && r_bit_cnt != 4'd8) begin
            w_shift_nxt   = {r_shift[6:0], w_sda_s};
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
            if (r_byte_cnt == 2'd2) begin
              w_state_nxt  = WAIT_STOP;
              w_sda_oe_nxt = 1'b0;
            end else begin
              w_state_nxt  = WR_ACK;
              w_sda_oe_nxt = 1'b1;
              if (r_byte_cnt == 2'd0) w_wr_hi_nxt = r_shift;
            end
          end
        end
        WR_ACK: begin
          if (w_scl_fall) begin
            w_sda_oe_nxt   = 1'b0;
            w_state_nxt    = WR_BYTE;
            w_bit_cnt_nxt  = 4'd0;
            w_byte_cnt_nxt = r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd1) begin
              w_rx_data_nxt  = {r_wr_hi, r_shift};
              w_rx_valid_nxt = 1'b1;
            end
          end
        end
        RD_BYTE: begin
          if (w_scl_rise && r_bit_cnt != 4'd8) begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_bit_cnt == 4'd8) begin
              w_state_nxt  = RD_ACK;
              w_sda_oe_nxt = 1'b0;
            end else begin
              w_sda_oe_nxt = ~r_shift[7];
              w_shift_nxt  = {r_shift[6:0], 1'b0};
            end
          end
        end
        RD_ACK: begin
          if (w_scl_rise) begin
            w_ack_nxt = ~w_sda_s;
          end else if (w_scl_fall) begin
            if (r_ack) begin
              w_state_nxt    = RD_BYTE;
              w_bit_cnt_nxt  = 4'd0;
              w_sda_oe_nxt   = ~w_rd_byte[7];
              w_shift_nxt    = {w_rd_byte[6:0], 1'b0};
              w_byte_cnt_nxt = (r_byte_cnt == 2'd2) ? 2'd2 : r_byte_cnt + 2'd1;
            end else begin
              w_state_nxt  = WAIT_STOP;
              w_sda_oe_nxt = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_byte_cnt <= '0;
      r_wr_hi    <= '0;
      r_tx_word  <= '0;
      r_ack      <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_wr_hi    <= w_wr_hi_nxt;
      r_tx_word  <= w_tx_word_nxt;
      r_ack      <= w_ack_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_busy     <= w_busy_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
    end

  assign sda_oe    = r_sda_oe;
  assign busy      = r_busy;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
// Directed bench for i2c_target: a bit-banged initiator on an open-drain SDA model,
// one task per scenario with inline checks against hand-computed values.
module tb_i2c_target;

  localparam int Q = 100;  // quarter SCL period in ns (10 clk)
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int RXV_LAT = 50;
`else
  localparam int RXV_LAT = 30;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_in;
  logic        sda_oe;
  logic [15:0] tx_data = 16'h0000;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        busy;
  logic [2:0]  dbg_state;

  int  n_checks = 0;
  int  n_fail = 0;
  int  rxv_cycles = 0;
  int  oe_cycles = 0;
  int  busy_cycles = 0;
  time t_rxv = 0;
  time t_fall = 0;

  assign sda_in = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target dut (
    .clk(clk), .reset_n(reset_n), .scl(scl), .sda_in(sda_in), .sda_oe(sda_oe),
    .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .dbg_state(dbg_state)
  );

  always @(negedge clk) begin
    if (rx_valid) begin rxv_cycles++; t_rxv = $time; end
    if (sda_oe) oe_cycles++;
    if (busy) busy_cycles++;
  end

  task automatic bus_bit(input logic b, output logic s);
    sda_m = b; #Q; scl = 1'b1; #Q; s = sda_in; #Q; scl = 1'b0; t_fall = $time; #Q;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin bus_bit(1'b1, s); d[i] = s; end
    bus_bit(~ack, s);
  endtask

  task automatic test_reset();
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    n_checks++; if (rx_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rx_data got=%h exp=0000", rx_data); end
    n_checks++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    reset_n = 1'b1; #Q;
  endtask

  task automatic test_write();
    logic a0, a1, a2; int rxv0; time lat;
    rxv0 = rxv_cycles;
    i2c_start(); write_byte(8'h98, a0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_after_match got=%b exp=1", busy); end
    write_byte(8'h12, a1); write_byte(8'h34, a2);
    lat = t_rxv - t_fall;
    n_checks++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL wr_acks got=%b exp=111", {a0, a1, a2}); end
    n_checks++; if (lat !== time'(RXV_LAT)) begin n_fail++; $display("FAIL wr_rxv_latency got=%0t exp=%0d", lat, RXV_LAT); end
    i2c_stop(); #Q;
    n_checks++; if (rx_data !== 16'h1234) begin n_fail++; $display("FAIL wr_rx_data got=%h exp=1234", rx_data); end
    n_checks++; if (rxv_cycles - rxv0 !== 1) begin n_fail++; $display("FAIL wr_rxv_cycles got=%0d exp=1", rxv_cycles - rxv0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_after_stop got=%b exp=0", busy); end
  endtask

  task automatic test_stop_after_byte0();
    logic a0, a1; int rxv0;
    rxv0 = rxv_cycles;
    i2c_start(); write_byte(8'h98, a0); write_byte(8'h77, a1); i2c_stop(); #Q;
    n_checks++; if ({a0, a1} !== 2'b11) begin n_fail++; $display("FAIL b0stop_acks got=%b exp=11", {a0, a1}); end
    n_checks++; if (rxv_cycles - rxv0 !== 0) begin n_fail++; $display("FAIL b0stop_rxv got=%0d exp=0", rxv_cycles - rxv0); end
    n_checks++; if (rx_data !== 16'h1234) begin n_fail++; $display("FAIL b0stop_rx_data got=%h exp=1234", rx_data); end
  endtask

  task automatic test_read();
    logic a; logic [7:0] b0, b1;
    tx_data = 16'hABCD;
    i2c_start(); write_byte(8'h99, a);
    tx_data = 16'h0000;
    read_byte(1'b1, b0); read_byte(1'b0, b1);
    n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL rd_addr_ack got=%b exp=1", a); end
    n_checks++; if (b0 !== 8'hAB) begin n_fail++; $display("FAIL rd_byte0 got=%h exp=ab", b0); end
    n_checks++; if (b1 !== 8'hCD) begin n_fail++; $display("FAIL rd_byte1 got=%h exp=cd", b1); end
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rd_released_after_nack got=%b exp=0", sda_oe); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy_before_stop got=%b exp=1", busy); end
    i2c_stop(); #Q;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_after_stop got=%b exp=0", busy); end
  endtask

  task automatic test_read_ff();
    logic a; logic [7:0] b0, b1, b2;
    tx_data = 16'h1357;
    i2c_start(); write_byte(8'h99, a);
    read_byte(1'b1, b0); read_byte(1'b1, b1); read_byte(1'b0, b2); i2c_stop(); #Q;
    n_checks++; if ({b0, b1, b2} !== 24'h1357FF) begin n_fail++; $display("FAIL rdff_bytes got=%h exp=1357ff", {b0, b1, b2}); end
  endtask

  task automatic test_mismatch();
    logic a0, a1; int oe0, bz0;
    oe0 = oe_cycles; bz0 = busy_cycles;
    i2c_start(); write_byte(8'h90, a0); write_byte(8'h5A, a1); i2c_stop(); #Q;
    n_checks++; if ({a0, a1} !== 2'b00) begin n_fail++; $display("FAIL mis_acks got=%b exp=00", {a0, a1}); end
    n_checks++; if (oe_cycles - oe0 !== 0) begin n_fail++; $display("FAIL mis_sda_oe_cycles got=%0d exp=0", oe_cycles - oe0); end
    n_checks++; if (busy_cycles - bz0 !== 0) begin n_fail++; $display("FAIL mis_busy_cycles got=%0d exp=0", busy_cycles - bz0); end
  endtask

  task automatic test_rep_start();
    logic a0, a1, a2; logic [7:0] b; int rxv0;
    tx_data = 16'h5AC3; rxv0 = rxv_cycles;
    i2c_start(); write_byte(8'h98, a0); write_byte(8'h55, a1);
    i2c_start(); write_byte(8'h99, a2); read_byte(1'b0, b); i2c_stop(); #Q;
    n_checks++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL rs_acks got=%b exp=111", {a0, a1, a2}); end
    n_checks++; if (b !== 8'h5A) begin n_fail++; $display("FAIL rs_read got=%h exp=5a", b); end
    n_checks++; if (rxv_cycles - rxv0 !== 0) begin n_fail++; $display("FAIL rs_rxv got=%0d exp=0", rxv_cycles - rxv0); end
    n_checks++; if (rx_data !== 16'h1234) begin n_fail++; $display("FAIL rs_rx_data got=%h exp=1234", rx_data); end
  endtask

  task automatic test_third_nack();
    logic a0, a1, a2, a3; int rxv0;
    rxv0 = rxv_cycles;
    i2c_start(); write_byte(8'h98, a0); write_byte(8'h01, a1); write_byte(8'h02, a2); write_byte(8'h03, a3);
    i2c_stop(); #Q;
    n_checks++; if ({a0, a1, a2, a3} !== 4'b1110) begin n_fail++; $display("FAIL nack3_acks got=%b exp=1110", {a0, a1, a2, a3}); end
    n_checks++; if (rx_data !== 16'h0102) begin n_fail++; $display("FAIL nack3_rx_data got=%h exp=0102", rx_data); end
    n_checks++; if (rxv_cycles - rxv0 !== 1) begin n_fail++; $display("FAIL nack3_rxv got=%0d exp=1", rxv_cycles - rxv0); end
  endtask

  task automatic test_reset_mid();
    logic s, a0, a1, a2, a3, a4; int oe0, bz0, rxv0;
    logic [7:0] addr;
    addr = 8'h98;
    i2c_start();
    for (int i = 7; i >= 0; i--) bus_bit(addr[i], s);
    sda_m = 1'b1; #Q; scl = 1'b1; #Q;
    n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rm_ack_driven got=%b exp=1", sda_oe); end
    reset_n = 1'b0; #1;
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rm_async_sda_oe got=%b exp=0", sda_oe); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_async_busy got=%b exp=0", busy); end
    #(Q - 1); reset_n = 1'b1; scl = 1'b0; #Q;
    oe0 = oe_cycles; bz0 = busy_cycles; rxv0 = rxv_cycles;
    write_byte(8'h12, a0); write_byte(8'h34, a1); i2c_stop(); #Q;
    n_checks++; if ({a0, a1} !== 2'b00) begin n_fail++; $display("FAIL rm_ignored_acks got=%b exp=00", {a0, a1}); end
    n_checks++; if (oe_cycles - oe0 + busy_cycles - bz0 + rxv_cycles - rxv0 !== 0) begin
      n_fail++; $display("FAIL rm_ignored_activity got=%0d exp=0", oe_cycles - oe0 + busy_cycles - bz0 + rxv_cycles - rxv0);
    end
    n_checks++; if (rx_data !== 16'h0000) begin n_fail++; $display("FAIL rm_rx_data_cleared got=%h exp=0000", rx_data); end
    i2c_start(); write_byte(8'h98, a2); write_byte(8'hAB, a3); write_byte(8'hCD, a4); i2c_stop(); #Q;
    n_checks++; if ({a2, a3, a4} !== 3'b111) begin n_fail++; $display("FAIL rm_new_acks got=%b exp=111", {a2, a3, a4}); end
    n_checks++; if (rx_data !== 16'hABCD) begin n_fail++; $display("FAIL rm_new_rx_data got=%h exp=abcd", rx_data); end
  endtask

  initial begin
    #20;
    test_reset();
    test_write();
    test_stop_after_byte0();
    test_read();
    test_read_ff();
    test_mismatch();
    test_rep_start();
    test_third_nack();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
